// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM bus arbiter: requester identity,
// response pipeline record and the full byte-enable constant.
package sram_arb_pkg;

  typedef enum logic {
    OwnerInstr = 1'b0,
    OwnerData  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   err;
  } resp_t;

  localparam logic [3:0] BeFull = 4'hF;

endpackage

// File: rtl/sram_arb_perf_cnt.sv
// Saturating event counter with synchronous clear; the clear takes priority
// over an increment in the same cycle.
module sram_arb_perf_cnt #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != {Width{1'b1}})) begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between the Ibex instruction
// and data buses. Optional counters are enabled with SRAM_BUS_ARBITER_PERF_EN.
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned MemSize      = 65536,
  parameter logic [31:0] MemStart     = 32'h00000000,
  parameter int unsigned PerfCntWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    instr_req_i,
  input  logic [31:0]             instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [31:0]             instr_rdata_o,
  output logic                    instr_err_o,

  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [3:0]              data_be_i,
  input  logic [31:0]             data_addr_i,
  input  logic [31:0]             data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [31:0]             data_rdata_o,
  output logic                    data_err_o,

  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [3:0]              mem_be_o,
  output logic [31:0]             mem_addr_o,
  output logic [31:0]             mem_wdata_o,
  input  logic                    mem_rvalid_i,
  input  logic [31:0]             mem_rdata_i
`ifdef SRAM_BUS_ARBITER_PERF_EN
  ,
  input  logic                    perf_clear_i,
  output logic [PerfCntWidth-1:0] perf_instr_gnt_o,
  output logic [PerfCntWidth-1:0] perf_data_gnt_o,
  output logic [PerfCntWidth-1:0] perf_conflict_o
`endif
);

  localparam logic [31:0] AddrMask = ~(32'(MemSize) - 32'd1);

  owner_e      last_owner_q;
  owner_e      winner;
  logic        any_req;
  logic        instr_win;
  logic        in_window;
  logic [31:0] sel_addr;
  resp_t       resp_d;
  resp_t       resp_q;

  // Instr wins unless data is also requesting and instr was served last.
  always_comb begin
    any_req   = instr_req_i | data_req_i;
    instr_win = instr_req_i & (~data_req_i | (last_owner_q == OwnerData));
    winner    = instr_win ? OwnerInstr : OwnerData;
    sel_addr  = instr_win ? instr_addr_i : data_addr_i;
    in_window = (sel_addr & AddrMask) == MemStart;
  end

  assign instr_gnt_o = instr_win;
  assign data_gnt_o  = data_req_i & ~instr_win;

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (any_req && in_window) begin
      mem_req_o  = 1'b1;
      mem_addr_o = sel_addr;
      if (instr_win) begin
        mem_be_o = BeFull;
      end else begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end
    end
  end

  always_comb begin
    resp_d = '0;
    if (any_req) begin
      resp_d.valid = 1'b1;
      resp_d.owner = winner;
      resp_d.err   = ~in_window;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_owner_q <= OwnerData;
      resp_q       <= '0;
    end else begin
      resp_q <= resp_d;
      if (any_req) begin
        last_owner_q <= winner;
      end
    end
  end

  // Error responses never carry SRAM data, so rdata is forced to zero.
  always_comb begin
    instr_rvalid_o = resp_q.valid && (resp_q.owner == OwnerInstr);
    data_rvalid_o  = resp_q.valid && (resp_q.owner == OwnerData);
    instr_err_o    = instr_rvalid_o && resp_q.err;
    data_err_o     = data_rvalid_o && resp_q.err;
    instr_rdata_o  = (instr_rvalid_o && !resp_q.err) ? mem_rdata_i : 32'h0;
    data_rdata_o   = (data_rvalid_o && !resp_q.err) ? mem_rdata_i : 32'h0;
  end

  mem_rvalid_consistent : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i == (resp_q.valid && !resp_q.err)
  );

`ifdef SRAM_BUS_ARBITER_PERF_EN
  sram_arb_perf_cnt #(.Width(PerfCntWidth)) u_cnt_instr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (perf_clear_i),
    .inc_i   (instr_gnt_o),
    .count_o (perf_instr_gnt_o)
  );

  sram_arb_perf_cnt #(.Width(PerfCntWidth)) u_cnt_data (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (perf_clear_i),
    .inc_i   (data_gnt_o),
    .count_o (perf_data_gnt_o)
  );

  sram_arb_perf_cnt #(.Width(PerfCntWidth)) u_cnt_conflict (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (perf_clear_i),
    .inc_i   (instr_req_i & data_req_i),
    .count_o (perf_conflict_o)
  );
`endif

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with a 1-cycle SRAM model; the counter
// scenario runs when SRAM_BUS_ARBITER_PERF_EN is defined.
module tb_sram_bus_arbiter;

  localparam int unsigned PerfW = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
`ifdef SRAM_BUS_ARBITER_PERF_EN
  logic             perf_clear_i;
  logic [PerfW-1:0] perf_instr_gnt_o, perf_data_gnt_o, perf_conflict_o;
`endif

  int checks = 0;
  int fails  = 0;

  logic [31:0] sram [0:16383];

  always #5 clk_i = ~clk_i;

  sram_bus_arbiter #(
    .MemSize      (65536),
    .MemStart     (32'h00000000),
    .PerfCntWidth (PerfW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i)
`ifdef SRAM_BUS_ARBITER_PERF_EN
    ,
    .perf_clear_i     (perf_clear_i),
    .perf_instr_gnt_o (perf_instr_gnt_o),
    .perf_data_gnt_o  (perf_data_gnt_o),
    .perf_conflict_o  (perf_conflict_o)
`endif
  );

  // Single-port SRAM model: read data and rvalid one cycle after the request.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_rvalid_i <= 1'b0;
      mem_rdata_i  <= 32'h0;
    end else begin
      mem_rvalid_i <= mem_req_o;
      if (mem_req_o) begin
        if (mem_we_o) begin
          for (int b = 0; b < 4; b++)
            if (mem_be_o[b]) sram[mem_addr_o[15:2]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
          mem_rdata_i <= 32'h0;
        end else begin
          mem_rdata_i <= sram[mem_addr_o[15:2]];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req_i  = 1'b0;
    instr_addr_i = 32'h0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'h0;
    data_addr_i  = 32'h0;
    data_wdata_i = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
`ifdef SRAM_BUS_ARBITER_PERF_EN
    perf_clear_i = 1'b0;
`endif
    rst_ni = 1'b0;
    #12;
    checks++;
    if ({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o, mem_req_o} !== 7'b0) begin
      fails++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
               {instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o, mem_req_o});
    end
    checks++;
    if ({instr_rdata_o, data_rdata_o} !== 64'h0) begin
      fails++;
      $display("[TB] FAIL reset_rdata: got %h %h expected 0 0", instr_rdata_o, data_rdata_o);
    end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_conflict();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h100;
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_be_i    = 4'h3;
    data_addr_i  = 32'h2000;
    data_wdata_i = 32'hA5A51234;
    #1;
    checks++;
    if ({instr_gnt_o, data_gnt_o, mem_addr_o} !== {2'b10, 32'h100}) begin
      fails++;
      $display("[TB] FAIL conflict_g1: got gnt %b%b addr %h expected 10 00000100", instr_gnt_o, data_gnt_o, mem_addr_o);
    end
    step();
    checks++;
    if ({instr_rvalid_o, data_rvalid_o, instr_err_o, instr_rdata_o} !== {3'b100, 32'hDEADBEEF}) begin
      fails++;
      $display("[TB] FAIL conflict_r1: got rv %b%b err %b rdata %h expected 10 0 deadbeef",
               instr_rvalid_o, data_rvalid_o, instr_err_o, instr_rdata_o);
    end
    checks++;
    if ({instr_gnt_o, data_gnt_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !==
        {4'b0111, 4'h3, 32'h2000, 32'hA5A51234}) begin
      fails++;
      $display("[TB] FAIL conflict_g2: got gnt %b%b req %b we %b be %h addr %h wdata %h expected 01 1 1 3 00002000 a5a51234",
               instr_gnt_o, data_gnt_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
    end
    step();
    checks++;
    if ({instr_rvalid_o, data_rvalid_o, data_err_o} !== 3'b010) begin
      fails++;
      $display("[TB] FAIL conflict_r2: got rv %b%b err %b expected 01 0", instr_rvalid_o, data_rvalid_o, data_err_o);
    end
    checks++;
    if ({instr_gnt_o, data_gnt_o, mem_we_o, mem_be_o} !== {3'b100, 4'hF}) begin
      fails++;
      $display("[TB] FAIL conflict_g3: got gnt %b%b we %b be %h expected 10 0 f", instr_gnt_o, data_gnt_o, mem_we_o, mem_be_o);
    end
    step();
    idle_inputs();
    checks++;
    if ({instr_rvalid_o, data_rvalid_o, instr_rdata_o} !== {2'b10, 32'hDEADBEEF}) begin
      fails++;
      $display("[TB] FAIL conflict_r3: got rv %b%b rdata %h expected 10 deadbeef", instr_rvalid_o, data_rvalid_o, instr_rdata_o);
    end
    checks++;
    if (sram[32'h2000 >> 2] !== 32'h11221234) begin
      fails++;
      $display("[TB] FAIL conflict_write: got sram %h expected 11221234", sram[32'h2000 >> 2]);
    end
    step();
  endtask

  task automatic test_single_instr();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h80;
    #1;
    checks++;
    if ({instr_gnt_o, data_gnt_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o} !== {4'b1010, 4'hF, 32'h80}) begin
      fails++;
      $display("[TB] FAIL single_gnt: got gnt %b%b req %b we %b be %h addr %h expected 10 1 0 f 00000080",
               instr_gnt_o, data_gnt_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o);
    end
    step();
    idle_inputs();
    checks++;
    if ({instr_rvalid_o, instr_err_o, data_rvalid_o, instr_rdata_o, data_rdata_o} !== {3'b100, 32'h13, 32'h0}) begin
      fails++;
      $display("[TB] FAIL single_resp: got rv %b err %b drv %b rdata %h drdata %h expected 1 0 0 00000013 0",
               instr_rvalid_o, instr_err_o, data_rvalid_o, instr_rdata_o, data_rdata_o);
    end
    step();
  endtask

  task automatic test_out_of_window();
    data_req_i  = 1'b1;
    data_addr_i = 32'h00010000;
    #1;
    checks++;
    if ({data_gnt_o, mem_req_o} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL oow_gnt: got gnt %b req %b expected 1 0", data_gnt_o, mem_req_o);
    end
    step();
    idle_inputs();
    checks++;
    if ({data_rvalid_o, data_err_o, data_rdata_o, instr_rvalid_o} !== {2'b11, 32'h0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL oow_resp: got rv %b err %b rdata %h irv %b expected 1 1 0 0",
               data_rvalid_o, data_err_o, data_rdata_o, instr_rvalid_o);
    end
    step();
  endtask

  task automatic test_back_to_back();
    data_req_i  = 1'b1;
    data_addr_i = 32'h10;
    step();
    checks++;
    if ({data_rvalid_o, data_err_o, data_rdata_o} !== {2'b10, 32'hCAFE0010}) begin
      fails++;
      $display("[TB] FAIL b2b_r1: got rv %b err %b rdata %h expected 1 0 cafe0010", data_rvalid_o, data_err_o, data_rdata_o);
    end
    data_addr_i = 32'h14;
    #1;
    checks++;
    if ({data_gnt_o, mem_req_o, mem_addr_o} !== {2'b11, 32'h14}) begin
      fails++;
      $display("[TB] FAIL b2b_g2: got gnt %b req %b addr %h expected 1 1 00000014", data_gnt_o, mem_req_o, mem_addr_o);
    end
    step();
    idle_inputs();
    checks++;
    if ({data_rvalid_o, data_rdata_o} !== {1'b1, 32'hCAFE0014}) begin
      fails++;
      $display("[TB] FAIL b2b_r2: got rv %b rdata %h expected 1 cafe0014", data_rvalid_o, data_rdata_o);
    end
    step();
    checks++;
    if ({data_rvalid_o, instr_rvalid_o} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL b2b_idle: got rv %b%b expected 00", data_rvalid_o, instr_rvalid_o);
    end
  endtask

  task automatic test_reset_mid();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h80;
    step();
    idle_inputs();
    rst_ni = 1'b0;
    #1;
    checks++;
    if (instr_rvalid_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rstmid_drop: got rvalid %b expected 0", instr_rvalid_o);
    end
    step();
    #2;
    rst_ni = 1'b1;
    step();
    checks++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL rstmid_norv: got rv %b%b expected 00", instr_rvalid_o, data_rvalid_o);
    end
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h80;
    data_req_i   = 1'b1;
    data_addr_i  = 32'h10;
    #1;
    checks++;
    if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL rstmid_ptr: got gnt %b%b expected 10", instr_gnt_o, data_gnt_o);
    end
    step();
    idle_inputs();
    step();
  endtask

`ifdef SRAM_BUS_ARBITER_PERF_EN
  task automatic test_perf();
    perf_clear_i = 1'b1;
    step();
    perf_clear_i = 1'b0;
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h80;
    data_req_i   = 1'b1;
    data_addr_i  = 32'h10;
    for (int i = 0; i < 20; i++) step();
    idle_inputs();
    checks++;
    if (perf_conflict_o !== 4'hF) begin
      fails++;
      $display("[TB] FAIL perf_sat: got conflict %h expected f", perf_conflict_o);
    end
    checks++;
    if ({perf_instr_gnt_o, perf_data_gnt_o} !== {4'hA, 4'hA}) begin
      fails++;
      $display("[TB] FAIL perf_gnt: got instr %h data %h expected a a", perf_instr_gnt_o, perf_data_gnt_o);
    end
    perf_clear_i = 1'b1;
    instr_req_i  = 1'b1;
    step();
    perf_clear_i = 1'b0;
    idle_inputs();
    checks++;
    if ({perf_instr_gnt_o, perf_data_gnt_o, perf_conflict_o} !== 12'h0) begin
      fails++;
      $display("[TB] FAIL perf_clear: got %h %h %h expected 0 0 0", perf_instr_gnt_o, perf_data_gnt_o, perf_conflict_o);
    end
    step();
  endtask
`endif

  initial begin
    for (int i = 0; i < 16384; i++) sram[i] = 32'h0;
    sram[32'h80 >> 2]   = 32'h00000013;
    sram[32'h100 >> 2]  = 32'hDEADBEEF;
    sram[32'h10 >> 2]   = 32'hCAFE0010;
    sram[32'h14 >> 2]   = 32'hCAFE0014;
    sram[32'h2000 >> 2] = 32'h11223344;

    test_reset();
    test_conflict();
    test_single_instr();
    test_out_of_window();
    test_back_to_back();
    test_reset_mid();
`ifdef SRAM_BUS_ARBITER_PERF_EN
    test_perf();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
